// File: rtl/activity_led_stretch.sv
// ---------------------------------------------------------------------------
// activity_led_stretch
//  Stretches 1-cycle event strobes (frame RX/TX and similar) into a visible
//  LED blink. Each blink has a guaranteed minimum ON time and a minimum OFF
//  gap. Events that arrive during a blink are merged into at most one
//  follow-on blink.
//
//  Parameters
//   N          prescaler width; one time tick every 2^N clk cycles
//   ON_TICKS   LED on-time in ticks (0 behaves as 1)
//   OFF_TICKS  forced off-gap in ticks (0 behaves as 1)
//   TW         tick-counter width; must hold max(ON_TICKS, OFF_TICKS)
//
//  Ports
//   clk      in   system clock, all logic on posedge
//   reset    in   asynchronous active-high reset
//   evt      in   event strobe, sampled every clk
//   led      out  registered LED drive, active-high
//   busy     out  registered, 1 whenever the FSM is not idle
//   pending  out  registered, 1 while a follow-on blink is queued
// ---------------------------------------------------------------------------
module activity_led_stretch #(
    parameter int unsigned N         = 19,
    parameter int unsigned ON_TICKS  = 3,
    parameter int unsigned OFF_TICKS = 3,
    parameter int unsigned TW        = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic evt,
    output logic led,
    output logic busy,
    output logic pending
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_ON   = 2'b01;
    localparam logic [1:0] S_OFF  = 2'b10;

    // Index of the final tick in each state; a zero count is treated as one tick.
    localparam logic [TW-1:0] ON_LAST  = (ON_TICKS  == 0) ? '0 : TW'(ON_TICKS  - 1);
    localparam logic [TW-1:0] OFF_LAST = (OFF_TICKS == 0) ? '0 : TW'(OFF_TICKS - 1);

    logic [1:0]    r_state;
    logic [N-1:0]  r_presc;
    logic [TW-1:0] r_tcnt;
    logic          r_pending;
    logic          r_led;
    logic          r_busy;

    logic [1:0]    w_state_nxt;
    logic [N-1:0]  w_presc_nxt;
    logic [TW-1:0] w_tcnt_nxt;
    logic          w_pending_nxt;
    logic          w_led_nxt;
    logic          w_busy_nxt;
    logic          w_tick;

    assign w_tick = (r_presc == {N{1'b1}});

    // State register, prescaler, tick counter and pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_tcnt    <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Next-state logic. Timers restart from zero on every entry to ON or OFF.
    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc + N'(1);
        w_tcnt_nxt    = r_tcnt + TW'(w_tick);
        w_pending_nxt = r_pending;
        case (r_state)
            S_IDLE: begin
                w_presc_nxt   = '0;
                w_tcnt_nxt    = '0;
                w_pending_nxt = 1'b0;
                if (evt) begin
                    w_state_nxt = S_ON;
                end
            end
            S_ON: begin
                if (evt) begin
                    w_pending_nxt = 1'b1;
                end
                if (w_tick && (r_tcnt == ON_LAST)) begin
                    w_state_nxt = S_OFF;
                    w_presc_nxt = '0;
                    w_tcnt_nxt  = '0;
                end
            end
            S_OFF: begin
                if (evt) begin
                    w_pending_nxt = 1'b1;
                end
                if (w_tick && (r_tcnt == OFF_LAST)) begin
                    // An event on the final OFF cycle counts as well as a queued one.
                    w_state_nxt   = (r_pending || evt) ? S_ON : S_IDLE;
                    w_presc_nxt   = '0;
                    w_tcnt_nxt    = '0;
                    w_pending_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_presc_nxt   = '0;
                w_tcnt_nxt    = '0;
                w_pending_nxt = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs align with it.
    always_comb begin
        w_led_nxt  = 1'b0;
        w_busy_nxt = 1'b0;
        if (w_state_nxt == S_ON) begin
            w_led_nxt = 1'b1;
        end
        if (w_state_nxt != S_IDLE) begin
            w_busy_nxt = 1'b1;
        end
    end

    // Registered LED and busy outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_led  <= w_led_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    assign led     = r_led;
    assign busy    = r_busy;
    assign pending = r_pending;

endmodule

// File: tb/tb_activity_led_stretch.sv
// ---------------------------------------------------------------------------
// tb_activity_led_stretch
//  Bench for activity_led_stretch with N=3, ON_TICKS=3, OFF_TICKS=2
//  (ON = 24 cycles, OFF = 16 cycles). A cycle-count reference model feeds a
//  scoreboard queue every cycle; a checkpoint table holds hand-derived
//  values for the event scenarios; short sequences cover async reset and an
//  illegal state encoding.
//  Cycle c is the interval after clock edge c; evt driven in cycle c is
//  sampled at edge c+1.
// ---------------------------------------------------------------------------
module tb_activity_led_stretch;

    localparam int unsigned N       = 3;
    localparam int unsigned ON_T    = 3;
    localparam int unsigned OFF_T   = 2;
    localparam int unsigned TW      = 4;
    localparam int          ON_CYC  = ON_T  * (1 << N);
    localparam int          OFF_CYC = OFF_T * (1 << N);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic evt   = 1'b0;
    logic led;
    logic busy;
    logic pending;

    always #5 clk = ~clk;

    activity_led_stretch #(
        .N         (N),
        .ON_TICKS  (ON_T),
        .OFF_TICKS (OFF_T),
        .TW        (TW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .evt     (evt),
        .led     (led),
        .busy    (busy),
        .pending (pending)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: 0 idle, 1 on, 2 off; timing by plain cycle counts.
    int   m_st   = 0;
    int   m_cnt  = 0;
    logic m_pend = 1'b0;

    logic [2:0] sb_q[$];

    typedef struct {
        int         scen;
        int         cyc;
        logic [2:0] exp;   // {led, busy, pending}
    } chk_t;

    chk_t tbl[$];

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got(led,busy,pend)=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_cnt  = 0;
        m_pend = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_step(input logic e);
        logic go;
        go = m_pend | e;
        case (m_st)
            0: begin
                if (e) begin
                    m_st  = 1;
                    m_cnt = 0;
                end
            end
            1: begin
                if (e) m_pend = 1'b1;
                if (m_cnt == ON_CYC - 1) begin
                    m_st  = 2;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            default: begin
                if (e) m_pend = 1'b1;
                if (m_cnt == OFF_CYC - 1) begin
                    m_st   = go ? 1 : 0;
                    m_cnt  = 0;
                    m_pend = 1'b0;
                end else begin
                    m_cnt++;
                end
            end
        endcase
    endtask

    // Drive one cycle of evt, queue the model's expectation, compare after the edge.
    task automatic step(input logic e);
        evt = e;
        model_step(e);
        sb_q.push_back({(m_st == 1), (m_st != 0), m_pend});
        @(posedge clk);
        #1;
        cyc++;
        if (sb_q.size() == 0) begin
            check("sb_empty", {led, busy, pending}, 3'bxxx);
        end else begin
            check("sb", {led, busy, pending}, sb_q.pop_front());
        end
    endtask

    task automatic do_reset();
        evt   = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {led, busy, pending}, 3'b000);
        reset = 1'b0;
        cyc   = 0;
    endtask

    function automatic logic evt_at(input int s, input int c);
        case (s)
            0:       return (c == 10);
            1:       return (c == 10) || (c == 15) || (c == 40);
            2:       return (c == 10) || (c == 34);
            3:       return (c >= 10);
            4:       return (c == 10) || (c == 50);
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        // Scenario 0: single pulse at 10
        tbl.push_back('{0, 10, 3'b000});
        tbl.push_back('{0, 11, 3'b110});
        tbl.push_back('{0, 34, 3'b110});
        tbl.push_back('{0, 35, 3'b010});
        tbl.push_back('{0, 50, 3'b010});
        tbl.push_back('{0, 51, 3'b000});
        // Scenario 1: pulses at 10, 15, 40 -> exactly one follow-on blink
        tbl.push_back('{1, 11, 3'b110});
        tbl.push_back('{1, 16, 3'b111});
        tbl.push_back('{1, 34, 3'b111});
        tbl.push_back('{1, 35, 3'b011});
        tbl.push_back('{1, 50, 3'b011});
        tbl.push_back('{1, 51, 3'b110});
        tbl.push_back('{1, 74, 3'b110});
        tbl.push_back('{1, 75, 3'b010});
        tbl.push_back('{1, 90, 3'b010});
        tbl.push_back('{1, 91, 3'b000});
        tbl.push_back('{1, 130, 3'b000});
        // Scenario 2: pulse on the final ON cycle
        tbl.push_back('{2, 34, 3'b110});
        tbl.push_back('{2, 35, 3'b011});
        tbl.push_back('{2, 50, 3'b011});
        tbl.push_back('{2, 51, 3'b110});
        tbl.push_back('{2, 75, 3'b010});
        tbl.push_back('{2, 91, 3'b000});
        // Scenario 3: evt held high from 10
        tbl.push_back('{3, 11, 3'b110});
        tbl.push_back('{3, 12, 3'b111});
        tbl.push_back('{3, 34, 3'b111});
        tbl.push_back('{3, 35, 3'b011});
        tbl.push_back('{3, 50, 3'b011});
        tbl.push_back('{3, 51, 3'b110});
        tbl.push_back('{3, 75, 3'b011});
        tbl.push_back('{3, 91, 3'b110});
        tbl.push_back('{3, 155, 3'b011});
        tbl.push_back('{3, 171, 3'b110});
        // Scenario 4: pulse on the final OFF cycle triggers ON directly
        tbl.push_back('{4, 50, 3'b010});
        tbl.push_back('{4, 51, 3'b110});
        tbl.push_back('{4, 52, 3'b110});
        tbl.push_back('{4, 91, 3'b000});

        for (int s = 0; s < 5; s++) begin
            int len;
            len = (s == 3) ? 200 : 140;
            do_reset();
            for (int c = 0; c < len; c++) begin
                step(evt_at(s, c));
                foreach (tbl[i]) begin
                    if (tbl[i].scen == s && tbl[i].cyc == cyc) begin
                        check($sformatf("tbl_s%0d", s), {led, busy, pending}, tbl[i].exp);
                    end
                end
            end
        end

        // Async reset between edges in the middle of ON, with a follow-on queued.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step((c == 10) || (c == 15));
        end
        check("pre_async_rst", {led, busy, pending}, 3'b111);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst", {led, busy, pending}, 3'b000);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_held", {led, busy, pending}, 3'b000);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step(1'b0);
        end
        step(1'b1);
        check("rst_then_evt", {led, busy, pending}, 3'b110);

        // Long quiet run after reset.
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            step(1'b0);
        end

        // Illegal state encoding recovers to IDLE with led=0.
        step(1'b1);
        check("pre_illegal", {led, busy, pending}, 3'b110);
        for (int c = 0; c < 4; c++) begin
            step(1'b0);
        end
        force dut.r_state = 2'b11;
        model_reset();
        step(1'b0);
        check("illegal_recover", {led, busy, pending}, 3'b000);
        release dut.r_state;
        step(1'b0);
        step(1'b1);
        check("post_illegal_evt", {led, busy, pending}, 3'b110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
